// File: rtl/muldiv_sequencer.sv
// Execute-stage MULT/MULTU/DIV/DIVU sequencer: single-cycle multiply, radix-2 restoring divide.
// Optional MDU_EARLY_TERM_EN: finish a divide in its first cycle when |divisor| > |dividend|.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// MUL   | full 2W product written to hi/lo
// DIV   | first cycle forms magnitudes and checks shortcuts, then WIDTH iterations
// DONE  | result_valid strobe for the HILO write
module muldiv_sequencer #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    output logic             stall_req,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic             isUnsigned;
    logic             negA;
    logic             negB;
    logic             divPrep;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;

    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               qBit;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   quoFix;
    logic [2*WIDTH-1:0] prodU;
    logic [2*WIDTH-1:0] prodS;

    // opA doubles as the quotient shift register once the divide iterations begin,
    // and opB then holds the divisor magnitude.
    assign magA    = negA ? -opA : opA;
    assign magB    = negB ? -opB : opB;
    assign shifted = {remReg, opA[WIDTH-1]};
    assign diff    = shifted - {1'b0, opB};
    assign qBit    = ~diff[WIDTH];
    assign remNext = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quoNext = {opA[WIDTH-2:0], qBit};
    assign quoFix  = (negA ^ negB) ? -quoNext : quoNext;
    assign remFix  = negA ? -remNext : remNext;

    assign prodU = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
    assign prodS = {{WIDTH{opA[WIDTH-1]}}, opA} * {{WIDTH{opB[WIDTH-1]}}, opB};

    assign stall_req    = (state == MUL) || (state == DIV) ||
                          ((state == IDLE) && start && !cancel);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE) && !cancel;
    assign hi           = hiReg;
    assign lo           = loReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            isUnsigned <= 1'b0;
            negA       <= 1'b0;
            negB       <= 1'b0;
            divPrep    <= 1'b0;
            cnt        <= '0;
            opA        <= '0;
            opB        <= '0;
            remReg     <= '0;
            hiReg      <= '0;
            loReg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        isUnsigned <= op[0];
                        negA       <= !op[0] && srca[WIDTH-1];
                        negB       <= !op[0] && srcb[WIDTH-1];
                        opA        <= srca;
                        opB        <= srcb;
                        divPrep    <= op[1];
                        cnt        <= '0;
                        remReg     <= '0;
                        state      <= op[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        {hiReg, loReg} <= isUnsigned ? prodU : prodS;
                        state          <= DONE;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else if (divPrep) begin
                        if (opB == '0) begin
                            hiReg <= opA;
                            loReg <= '1;
                            state <= DONE;
`ifdef MDU_EARLY_TERM_EN
                        end else if (magB > magA) begin
                            hiReg <= opA;
                            loReg <= '0;
                            state <= DONE;
`endif
                        end else begin
                            opA     <= magA;
                            opB     <= magB;
                            remReg  <= '0;
                            cnt     <= '0;
                            divPrep <= 1'b0;
                        end
                    end else begin
                        opA    <= quoNext;
                        remReg <= remNext;
                        cnt    <= cnt + CNT_ONE;
                        if (cnt == LAST_CNT) begin
                            hiReg <= remFix;
                            loReg <= quoFix;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         cancel;
    logic         stall_req;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int nVec = 0;
    int errs = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .cancel(cancel), .stall_req(stall_req), .busy(busy),
        .result_valid(result_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic with the MIPS corner cases.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int lat);
        int          sa;
        int          sb;
        longint      ps;
        longint      ma;
        longint      mb;
        logic [63:0] pu;
        sa = a;
        sb = b;
        lat = 2;
        if (o == 2'b00) begin
            ps = longint'(sa) * longint'(sb);
            {eh, el} = ps;
        end else if (o == 2'b01) begin
            pu = {32'b0, a} * {32'b0, b};
            {eh, el} = pu;
        end else if (b == 0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else begin
            lat = 34;
            if (o == 2'b10) begin
                if (sa == 32'sh8000_0000 && sb == -1) begin
                    el = 32'h8000_0000;
                    eh = 32'h0;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
                ma = (sa < 0) ? -longint'(sa) : longint'(sa);
                mb = (sb < 0) ? -longint'(sb) : longint'(sb);
            end else begin
                el = a / b;
                eh = a % b;
                ma = longint'({32'b0, a});
                mb = longint'({32'b0, b});
            end
`ifdef MDU_EARLY_TERM_EN
            if (mb > ma) lat = 2;
`endif
            if (ma < 0 || mb < 0) lat = -1;
        end
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        int          lat;
        int          cyc;
        model(o, a, b, eh, el, lat);
        op = o; srca = a; srcb = b; start = 1'b1;
        #1;
        check({tag, " stall_c0"}, stall_req, 1);
        check({tag, " valid_c0"}, result_valid, 0);
        tick;
        start = 1'b0;
        srca = $urandom;
        srcb = $urandom;
        cyc = 1;
        while (result_valid !== 1'b1 && cyc < 60) begin
            check({tag, " stall_busy"}, stall_req, 1);
            tick;
            cyc++;
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        check({tag, " stall_done"}, stall_req, 0);
        tick;
        check({tag, " valid_after"}, result_valid, 0);
        check({tag, " busy_after"}, busy, 0);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        tick;
        tick;
        check("reset busy", busy, 0);
        check("reset valid", result_valid, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset stall", stall_req, 0);
        rst = 1'b0;
        tick;

        runOp(2'b00, 32'hFFFF_FFFD, 32'h5, "mult_neg3x5");
        runOp(2'b11, 32'd100, 32'd7, "divu_100_7");
        runOp(2'b10, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        runOp(2'b11, 32'd5, 32'd0, "divu_by0");

        // Cancel a divide at c10; a stray start mid-op must be ignored.
        op = 2'b10; srca = 32'd100; srcb = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            start = (c == 4);
            op = 2'b00;
            check("cancel no_valid", result_valid, 0);
            tick;
        end
        start = 1'b0;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        check("cancel busy", busy, 0);
        check("cancel valid", result_valid, 0);
        check("cancel hi", hi, 32'h5);
        check("cancel lo", lo, 32'hFFFF_FFFF);
        for (int c = 0; c < 3; c++) begin
            tick;
            check("cancel quiet", result_valid, 0);
        end

        // Reset at c5 of a divide, then a MULTU at c7.
        op = 2'b10; srca = 32'd1000; srcb = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst busy", busy, 0);
        check("rst valid", result_valid, 0);
        tick;
        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");

        // Cancel a multiply: hi/lo must keep the MULTU result.
        op = 2'b00; srca = 32'd9; srcb = 32'd9; start = 1'b1;
        tick;
        start = 1'b0;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        check("mcancel busy", busy, 0);
        check("mcancel hi", hi, 32'hFFFF_FFFE);
        check("mcancel lo", lo, 32'h0000_0001);
        tick;
        check("mcancel valid", result_valid, 0);

        for (int i = 0; i < 40; i++) begin
            runOp(2'($urandom_range(0, 3)), pickVal(), pickVal(), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, errs);
        $finish;
    end
endmodule
